// File: rtl/uart_word_loader_pkg.sv
// Shared types and constants for the UART word loader.
// Holds the receiver state enum and byte/frame widths.
package uart_loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTE_W         = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_word_loader_if.sv
// Word write bus from the loader to the CPU memories.
// WE strobe, WSEL memory select, WADDR word address, WDATA word.
interface uart_word_loader_if #(
    parameter int ADDR_W = 14,
    parameter int WORD_W = 32
);

    logic              WE;
    logic              WSEL;
    logic [ADDR_W-1:0] WADDR;
    logic [WORD_W-1:0] WDATA;

    modport master (output WE, WSEL, WADDR, WDATA);
    modport slave  (input  WE, WSEL, WADDR, WDATA);

endinterface

// File: rtl/uart_word_loader_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, frame FSM, baud counter.
// Ports: clk, rst_n (sync, active low), rx in; byte_valid/data/err/busy out.
// Optional even parity bit when UART_LOADER_PARITY_EN is defined.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] data,
    output logic              err,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic              sync1;
    logic              rx_s;
    rx_state_e         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        bit_idx, bit_n;
    logic [BYTE_W-1:0] shreg, sh_n;
    logic              tick;
`ifdef UART_LOADER_PARITY_EN
    logic              par_ok, par_n;
`endif

    assign tick = (cnt == '0);
    assign data = shreg;
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_LOADER_PARITY_EN
            par_ok  <= 1'b0;
`endif
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
`ifdef UART_LOADER_PARITY_EN
            par_ok  <= par_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_idx;
        sh_n       = shreg;
        byte_valid = 1'b0;
        err        = 1'b0;
`ifdef UART_LOADER_PARITY_EN
        par_n      = par_ok;
`endif
        unique case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_n = RX_START;
                    cnt_n   = HALF;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    // start bit gone by mid-bit: treat as noise
                    state_n = RX_IDLE;
                end else begin
                    state_n = RX_DATA;
                    cnt_n   = FULL;
                    bit_n   = '0;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    sh_n  = {rx_s, shreg[BYTE_W-1:1]};
                    cnt_n = FULL;
                    bit_n = bit_idx + 1'b1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_LOADER_PARITY_EN
                        state_n = RX_PAR;
`else
                        state_n = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_LOADER_PARITY_EN
            RX_PAR: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_n   = (rx_s == ^shreg);
                    cnt_n   = FULL;
                    state_n = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = RX_IDLE;
`ifdef UART_LOADER_PARITY_EN
                    if (rx_s && par_ok) byte_valid = 1'b1;
                    else                err        = 1'b1;
`else
                    if (rx_s) byte_valid = 1'b1;
                    else      err        = 1'b1;
`endif
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_loader.sv
// UART loader: packs bytes MSB-first into words, data memory before DELIM.
// Ports: CLK, INITIALIZE_N, UART_RX in; wr bus, FRAME_ERR, BUSY out.
// Define UART_LOADER_PARITY_EN for 11-bit frames with even parity.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_W       = 14,
    parameter logic [8*WORD_BYTES-1:0] DELIM = '1
) (
    input  logic               CLK,
    input  logic               INITIALIZE_N,
    input  logic               UART_RX,
    uart_word_loader_if.master wr,
    output logic               FRAME_ERR,
    output logic               BUSY
);

    localparam int WORD_W = 8 * WORD_BYTES;

    logic              byte_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_err;
    logic [3:0]        byte_cnt;
    logic [WORD_W-1:0] word_next;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              wsel;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (CLK),
        .rst_n     (INITIALIZE_N),
        .rx        (UART_RX),
        .byte_valid(byte_valid),
        .data      (rx_data),
        .err       (rx_err),
        .busy      (BUSY)
    );

    // Only the earlier bytes of a word need storing; the last one
    // arrives straight from the receiver.
    generate
        if (WORD_BYTES == 1) begin : g_one
            assign word_next = rx_data;
        end else begin : g_multi
            logic [WORD_W-BYTE_W-1:0] part;
            always_ff @(posedge CLK) begin
                if (!INITIALIZE_N)  part <= '0;
                else if (byte_valid) part <= word_next[WORD_W-BYTE_W-1:0];
            end
            assign word_next = {part, rx_data};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!INITIALIZE_N) begin
            byte_cnt  <= '0;
            addr      <= '0;
            we        <= 1'b0;
            wsel      <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            frame_err <= 1'b0;
        end else begin
            we        <= 1'b0;
            frame_err <= rx_err;
            if (rx_err) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                if (byte_cnt == 4'(WORD_BYTES - 1)) begin
                    byte_cnt <= '0;
                    if (!wsel && word_next == DELIM) begin
                        wsel <= 1'b1;
                        addr <= '0;
                    end else begin
                        we    <= 1'b1;
                        waddr <= addr;
                        wdata <= word_next;
                        addr  <= addr + 1'b1;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    assign wr.WE     = we;
    assign wr.WSEL   = wsel;
    assign wr.WADDR  = waddr;
    assign wr.WDATA  = wdata;
    assign FRAME_ERR = frame_err;

endmodule
